// File: rtl/cptra_ss_rst_seq_pkg.sv
// cptra_ss_rst_seq_pkg: shared types and defaults for the subsystem reset sequencer.
// Holds the FSM state encoding, default delays, counter width and a saturating helper.
package cptra_ss_rst_seq_pkg;

    localparam int unsigned CNT_W            = 16;
    localparam int unsigned FABRIC_DLY_DEF   = 4;
    localparam int unsigned CPTRA_DLY_DEF    = 16;
    localparam int unsigned MCU_DLY_DEF      = 32;
    localparam int unsigned HALT_TIMEOUT_DEF = 256;
    localparam int unsigned MIN_ASSERT_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REL_FABRIC = 3'd1,
        REL_CPTRA  = 3'd2,
        REL_MCU    = 3'd3,
        RUN        = 3'd4,
        HALT       = 3'd5,
        ASSERT     = 3'd6
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cptra_ss_rst_sequencer_if.sv
// cptra_ss_rst_sequencer_if: MCU halt handshake, staged reset outputs and status.
// master = sequencer (drives resets/status/halt req), slave = consumer (drives halt ack).
interface cptra_ss_rst_sequencer_if;

    logic       mcu_halt_ack_i;
    logic       mcu_halt_req_o;
    logic       fabric_rst_b_o;
    logic       cptra_rst_b_o;
    logic       mcu_rst_b_o;
    logic       halt_timeout_o;
    logic [7:0] warm_rst_cnt_o;
    logic [2:0] seq_state_o;

    modport master (
        input  mcu_halt_ack_i,
        output mcu_halt_req_o,
        output fabric_rst_b_o,
        output cptra_rst_b_o,
        output mcu_rst_b_o,
        output halt_timeout_o,
        output warm_rst_cnt_o,
        output seq_state_o
    );

    modport slave (
        output mcu_halt_ack_i,
        input  mcu_halt_req_o,
        input  fabric_rst_b_o,
        input  cptra_rst_b_o,
        input  mcu_rst_b_o,
        input  halt_timeout_o,
        input  warm_rst_cnt_o,
        input  seq_state_o
    );

endinterface

// File: rtl/caliptra_2ff_sync.sv
// caliptra_2ff_sync: two-flop synchronizer, both flops cleared by rst_b.
// Ports: clk, rst_b (async active-low), d (async in), q (synchronized out).
module caliptra_2ff_sync (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/cptra_ss_rst_sequencer.sv
// cptra_ss_rst_sequencer: staged fabric/Caliptra/MCU reset release with MCU halt handshake.
// Ports: clk, cptra_pwrgood (cold, async low), cptra_rst_b (warm request), bus (master).
module cptra_ss_rst_sequencer
    import cptra_ss_rst_seq_pkg::*;
#(
    parameter int unsigned FABRIC_DLY   = FABRIC_DLY_DEF,
    parameter int unsigned CPTRA_DLY    = CPTRA_DLY_DEF,
    parameter int unsigned MCU_DLY      = MCU_DLY_DEF,
    parameter int unsigned HALT_TIMEOUT = HALT_TIMEOUT_DEF,
    parameter int unsigned MIN_ASSERT   = MIN_ASSERT_DEF
) (
    input  logic                     clk,
    input  logic                     cptra_pwrgood,
    input  logic                     cptra_rst_b,
    cptra_ss_rst_sequencer_if.master bus
);

    localparam int unsigned CNT_MAX = 2 ** CNT_W;

    if (FABRIC_DLY < 1 || FABRIC_DLY >= CNT_MAX) begin : g_bad_fab
        $error("FABRIC_DLY out of range");
    end
    if (CPTRA_DLY < 1 || CPTRA_DLY >= CNT_MAX) begin : g_bad_cptra
        $error("CPTRA_DLY out of range");
    end
    if (MCU_DLY < 1 || MCU_DLY >= CNT_MAX) begin : g_bad_mcu
        $error("MCU_DLY out of range");
    end
    if (HALT_TIMEOUT < 1 || HALT_TIMEOUT >= CNT_MAX) begin : g_bad_to
        $error("HALT_TIMEOUT out of range");
    end
    if (MIN_ASSERT < 1 || MIN_ASSERT >= CNT_MAX) begin : g_bad_ma
        $error("MIN_ASSERT out of range");
    end

    localparam logic [CNT_W-1:0] FAB_END = CNT_W'(FABRIC_DLY - 1);
    localparam logic [CNT_W-1:0] CPT_END = CNT_W'(CPTRA_DLY - 1);
    localparam logic [CNT_W-1:0] MCU_END = CNT_W'(MCU_DLY - 1);
    localparam logic [CNT_W-1:0] TO_END  = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MA_END  = CNT_W'(MIN_ASSERT - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_sync;
    logic             set_to;
    logic             fab_d, cpt_d, mcu_d, halt_d;
    logic             fab_q, cpt_q, mcu_q, halt_q;
    logic             to_q;
    logic [7:0]       wcnt_q;

    caliptra_2ff_sync u_req_sync (
        .clk   (clk),
        .rst_b (cptra_pwrgood),
        .d     (cptra_rst_b),
        .q     (req_sync)
    );

    // A warm request dropping while the MCU is still held skips the halt
    // handshake; the drop takes priority over the dwell exit.
    always_comb begin
        state_d = state_q;
        set_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_sync) state_d = REL_FABRIC;
            end
            REL_FABRIC: begin
                if (!req_sync)            state_d = ASSERT;
                else if (cnt_q == FAB_END) state_d = REL_CPTRA;
            end
            REL_CPTRA: begin
                if (!req_sync)            state_d = ASSERT;
                else if (cnt_q == CPT_END) state_d = REL_MCU;
            end
            REL_MCU: begin
                if (!req_sync)            state_d = ASSERT;
                else if (cnt_q == MCU_END) state_d = RUN;
            end
            RUN: begin
                if (!req_sync) state_d = HALT;
            end
            HALT: begin
                if (bus.mcu_halt_ack_i) begin
                    state_d = ASSERT;
                end else if (cnt_q == TO_END) begin
                    state_d = ASSERT;
                    set_to  = 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == MA_END) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they switch on the same edge
    // as the state register.
    always_comb begin
        fab_d  = (state_d == REL_CPTRA) || (state_d == REL_MCU) ||
                 (state_d == RUN) || (state_d == HALT);
        cpt_d  = (state_d == REL_MCU) || (state_d == RUN) ||
                 (state_d == HALT);
        mcu_d  = (state_d == RUN) || (state_d == HALT);
        halt_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge cptra_pwrgood) begin
        if (!cptra_pwrgood) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fab_q   <= 1'b0;
            cpt_q   <= 1'b0;
            mcu_q   <= 1'b0;
            halt_q  <= 1'b0;
            to_q    <= 1'b0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            fab_q   <= fab_d;
            cpt_q   <= cpt_d;
            mcu_q   <= mcu_d;
            halt_q  <= halt_d;
            if (set_to) to_q <= 1'b1;
            if (state_d == ASSERT && state_q != ASSERT)
                wcnt_q <= sat_inc8(wcnt_q);
        end
    end

    assign bus.mcu_halt_req_o = halt_q;
    assign bus.fabric_rst_b_o = fab_q;
    assign bus.cptra_rst_b_o  = cpt_q;
    assign bus.mcu_rst_b_o    = mcu_q;
    assign bus.halt_timeout_o = to_q;
    assign bus.warm_rst_cnt_o = wcnt_q;
    assign bus.seq_state_o    = state_q;

endmodule

// File: tb/tb_cptra_ss_rst_sequencer.sv
// tb_cptra_ss_rst_sequencer: directed bench with an edge-timing scoreboard.
// Expected output transitions are queued when stimulus is driven, then matched.
module tb_cptra_ss_rst_sequencer;

    logic clk = 1'b0;
    logic cptra_pwrgood = 1'b0;
    logic cptra_rst_b = 1'b0;

    cptra_ss_rst_sequencer_if bus ();

    cptra_ss_rst_sequencer dut (
        .clk           (clk),
        .cptra_pwrgood (cptra_pwrgood),
        .cptra_rst_b   (cptra_rst_b),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        string       tag;
        int          sel;
        logic        lvl;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    localparam int S_FAB  = 0;
    localparam int S_CPT  = 1;
    localparam int S_MCU  = 2;
    localparam int S_HALT = 3;
    localparam int S_TO   = 4;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_FAB:   return bus.fabric_rst_b_o;
            S_CPT:   return bus.cptra_rst_b_o;
            S_MCU:   return bus.mcu_rst_b_o;
            S_HALT:  return bus.mcu_halt_req_o;
            default: return bus.halt_timeout_o;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic lvl,
                        input int unsigned at);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.lvl = lvl;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Pop each expected transition and measure the edge it actually occurs on.
    task automatic drain();
        exp_t e;
        int unsigned lim;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            lim = e.at + 16;
            while (sig(e.sel) !== e.lvl && edge_cnt < lim) tick(1);
            check(e.tag, edge_cnt, e.at);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound,
                              output bit ok);
        int n;
        n = 0;
        while (bus.seq_state_o !== s && n < bound) begin
            tick(1);
            n++;
        end
        ok = (bus.seq_state_o === s);
    endtask

    task automatic chk_all_zero(input string pfx);
        check({pfx, "_fab"},   bus.fabric_rst_b_o, 0);
        check({pfx, "_cpt"},   bus.cptra_rst_b_o, 0);
        check({pfx, "_mcu"},   bus.mcu_rst_b_o, 0);
        check({pfx, "_halt"},  bus.mcu_halt_req_o, 0);
        check({pfx, "_to"},    bus.halt_timeout_o, 0);
        check({pfx, "_wcnt"},  bus.warm_rst_cnt_o, 0);
        check({pfx, "_state"}, bus.seq_state_o, 0);
    endtask

    initial begin
        int unsigned r;
        int unsigned a;
        bit ok1, ok2, halt_seen;
        int tmo;
        int exp_w;

        bus.mcu_halt_ack_i = 1'b0;
        tick(3);
        chk_all_zero("rst");
        cptra_pwrgood = 1'b1;
        tick(3);
        check("idle_hold", bus.seq_state_o, 0);

        // Cold boot
        cptra_rst_b = 1'b1;
        r = edge_cnt;
        push("cold_fab", S_FAB, 1'b1, r + 7);
        push("cold_cpt", S_CPT, 1'b1, r + 23);
        push("cold_mcu", S_MCU, 1'b1, r + 55);
        drain();
        check("cold_run", bus.seq_state_o, 4);

        // Warm reset, ack 5 cycles after halt request
        tick(2);
        cptra_rst_b = 1'b0;
        r = edge_cnt;
        push("w1_halt", S_HALT, 1'b1, r + 3);
        drain();
        tick(5);
        bus.mcu_halt_ack_i = 1'b1;
        r = edge_cnt;
        push("w1_fab0",  S_FAB,  1'b0, r + 1);
        push("w1_cpt0",  S_CPT,  1'b0, r + 1);
        push("w1_mcu0",  S_MCU,  1'b0, r + 1);
        push("w1_halt0", S_HALT, 1'b0, r + 1);
        drain();
        bus.mcu_halt_ack_i = 1'b0;
        check("w1_state", bus.seq_state_o, 6);
        check("w1_wcnt", bus.warm_rst_cnt_o, 1);
        check("w1_to", bus.halt_timeout_o, 0);
        tick(7);
        check("w1_hold_state", bus.seq_state_o, 6);
        check("w1_hold_fab", bus.fabric_rst_b_o, 0);
        tick(1);
        check("w1_idle", bus.seq_state_o, 0);

        // Warm reset with no ack: timeout
        cptra_rst_b = 1'b1;
        r = edge_cnt;
        push("w2_mcu", S_MCU, 1'b1, r + 55);
        drain();
        cptra_rst_b = 1'b0;
        r = edge_cnt;
        push("w2_halt", S_HALT, 1'b1, r + 3);
        drain();
        r = edge_cnt;
        push("w2_to",   S_TO,  1'b1, r + 256);
        push("w2_fab0", S_FAB, 1'b0, r + 256);
        drain();
        check("w2_wcnt", bus.warm_rst_cnt_o, 2);
        tick(8);
        check("w2_idle", bus.seq_state_o, 0);
        cptra_rst_b = 1'b1;
        r = edge_cnt;
        push("w2r_fab", S_FAB, 1'b1, r + 7);
        push("w2r_cpt", S_CPT, 1'b1, r + 23);
        push("w2r_mcu", S_MCU, 1'b1, r + 55);
        drain();
        check("w2_to_sticky", bus.halt_timeout_o, 1);

        // 2-cycle glitch in RUN
        cptra_rst_b = 1'b0;
        r = edge_cnt;
        tick(2);
        cptra_rst_b = 1'b1;
        push("g_halt", S_HALT, 1'b1, r + 3);
        drain();
        tick(2);
        bus.mcu_halt_ack_i = 1'b1;
        r = edge_cnt;
        push("g_fab0", S_FAB, 1'b0, r + 1);
        push("g_mcu0", S_MCU, 1'b0, r + 1);
        drain();
        bus.mcu_halt_ack_i = 1'b0;
        a = edge_cnt;
        push("g_refab", S_FAB, 1'b1, a + 13);
        drain();
        check("g_wcnt", bus.warm_rst_cnt_o, 3);

        // Drop during REL_CPTRA: no halt handshake
        tick(3);
        check("d_state_pre", bus.seq_state_o, 2);
        cptra_rst_b = 1'b0;
        halt_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.mcu_halt_req_o !== 1'b0) halt_seen = 1'b1;
            if (i == 1) check("d_fab_hi", bus.fabric_rst_b_o, 1);
        end
        check("d_fab_lo", bus.fabric_rst_b_o, 0);
        check("d_state", bus.seq_state_o, 6);
        check("d_no_halt", halt_seen, 0);
        check("d_wcnt", bus.warm_rst_cnt_o, 4);

        // Power-good drop mid-HALT
        tick(8);
        cptra_rst_b = 1'b1;
        r = edge_cnt;
        push("p_mcu", S_MCU, 1'b1, r + 55);
        drain();
        cptra_rst_b = 1'b0;
        r = edge_cnt;
        push("p_halt", S_HALT, 1'b1, r + 3);
        drain();
        tick(2);
        #2;
        cptra_pwrgood = 1'b0;
        #1;
        chk_all_zero("pg");
        tick(1);
        cptra_pwrgood = 1'b1;
        tick(1);

        // 300 warm resets through the REL_FABRIC drop path
        tmo = 0;
        exp_w = 0;
        for (int i = 0; i < 300; i++) begin
            cptra_rst_b = 1'b1;
            wait_state(3'd1, 20, ok1);
            cptra_rst_b = 1'b0;
            wait_state(3'd0, 30, ok2);
            if (!ok1 || !ok2) begin
                tmo++;
                break;
            end
            exp_w = (exp_w == 255) ? 255 : exp_w + 1;
            if (i == 99) check("sat_100", bus.warm_rst_cnt_o, exp_w);
        end
        check("sat_wait", tmo, 0);
        check("sat_255", bus.warm_rst_cnt_o, 255);
        check("sat_to_clr", bus.halt_timeout_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
